spi_master_ram_ctrl: RTL

//  SPI master that drives the team's SPI slave + single-port RAM block from a parallel command port.

---
 rtl/spi_master_ram_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/spi_master_ram_ctrl.sv
// SPI master that frames one {op, byte} command per SS_n-low window and,
// for read-data commands, captures the 8-bit reply shifted in on MISO.
module spi_master_ram_ctrl #(
    parameter int RD_LAT = 2,
    parameter int GAP    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);
    localparam int MAX_A   = (RD_LAT > 10) ? RD_LAT : 10;
    localparam int MAX_CNT = (GAP > MAX_A) ? GAP : MAX_A;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_WAIT_RD,
        ST_RECV,
        ST_END
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [9:0]       shreg_reg, shreg_next;
    logic [1:0]       op_reg, op_next;
    logic [7:0]       rx_reg, rx_next;
    logic [7:0]       rsp_data_reg, rsp_data_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic             ss_n_reg, ss_n_next;
    logic             mosi_reg, mosi_next;

    // SS_n and MOSI are registered, so the next-state logic computes the
    // pin values for the cycle that follows the current one.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shreg_next     = shreg_reg;
        op_next        = op_reg;
        rx_next        = rx_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_valid_next = 1'b0;
        ss_n_next      = 1'b1;
        mosi_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    shreg_next = {cmd_op, cmd_data};
                    op_next    = cmd_op;
                    state_next = ST_START;
                    ss_n_next  = 1'b0;
                    mosi_next  = cmd_op[1];
                end
            end
            ST_START: begin
                state_next = ST_SHIFT;
                cnt_next   = '0;
                ss_n_next  = 1'b0;
                mosi_next  = shreg_reg[9];
            end
            ST_SHIFT: begin
                shreg_next = {shreg_reg[8:0], 1'b0};
                if (cnt_reg == CNT_W'(9)) begin
                    cnt_next = '0;
                    if (op_reg == 2'b11) begin
                        ss_n_next  = 1'b0;
                        state_next = (RD_LAT > 0) ? ST_WAIT_RD : ST_RECV;
                    end else begin
                        state_next = ST_END;
                    end
                end else begin
                    cnt_next  = cnt_reg + 1'b1;
                    ss_n_next = 1'b0;
                    mosi_next = shreg_reg[8];
                end
            end
            ST_WAIT_RD: begin
                ss_n_next = 1'b0;
                if (cnt_reg == CNT_W'(RD_LAT - 1)) begin
                    cnt_next   = '0;
                    state_next = ST_RECV;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RECV: begin
                // MISO is only looked at here, so an undriven line elsewhere is harmless
                rx_next = {rx_reg[6:0], MISO};
                if (cnt_reg == CNT_W'(7)) begin
                    cnt_next       = '0;
                    state_next     = ST_END;
                    rsp_valid_next = 1'b1;
                    rsp_data_next  = {rx_reg[6:0], MISO};
                end else begin
                    cnt_next  = cnt_reg + 1'b1;
                    ss_n_next = 1'b0;
                end
            end
            ST_END: begin
                if (cnt_reg == CNT_W'(GAP - 1)) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            shreg_reg     <= '0;
            op_reg        <= '0;
            rx_reg        <= '0;
            rsp_data_reg  <= '0;
            rsp_valid_reg <= 1'b0;
            ss_n_reg      <= 1'b1;
            mosi_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shreg_reg     <= shreg_next;
            op_reg        <= op_next;
            rx_reg        <= rx_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_valid_reg <= rsp_valid_next;
            ss_n_reg      <= ss_n_next;
            mosi_reg      <= mosi_next;
        end
    end

    assign cmd_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign SS_n      = ss_n_reg;
    assign MOSI      = mosi_reg;

endmodule
